// File: rtl/mips16_pkg.sv
// Shared MIPS-16 datapath definitions.
// Width, divider FSM states, DIV/DIVU function codes.
package mips16_pkg;

    localparam int WIDTH = 16;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // -32768 maps to 16'h8000, read as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        return (s && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/div_unit_16_if.sv
// Request/response bundle between control unit and divider.
// Master is the control unit, slave is div_unit_16.
interface div_unit_16_if;
    import mips16_pkg::*;

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );

endinterface

// File: rtl/div_unit_16_step.sv
// One combinational restoring-division step.
// The kept partial always fits WIDTH bits since it stays below the divisor.
module div_step
    import mips16_pkg::*;
(
    input  logic [WIDTH:0]   part_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] part_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    assign trial    = part_in - {1'b0, dsr};
    assign q_bit    = ~trial[WIDTH];
    assign part_out = q_bit ? trial[WIDTH-1:0]
                            : part_in[WIDTH-1:0];

endmodule

// File: rtl/div_unit_16.sv
// Multi-cycle 16-bit restoring divider for DIV/DIVU.
// One quotient bit per clock, sign fix-up in a final cycle.
module div_unit_16
    import mips16_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    div_unit_16_if.slave bus
);

    div_state_t       state_q, state_d;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             done_q;
    logic             dz_q;

    logic             accept;
    logic             zero_div;
    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;

    assign accept   = (state_q == IDLE) && bus.start;
    assign zero_div = (bus.divisor == '0);

    div_step u_step (
        .part_in  ({rem_q, dvd_q[WIDTH-1]}),
        .dsr      (dsr_q),
        .part_out (rem_nx),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !zero_div) state_d = CALC;
            CALC:    if (cnt_q == 4'd15) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Quotient bits shift into the dividend register as it empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                dz_q <= zero_div;
                if (zero_div) begin
                    quo_q  <= '1;
                    rmd_q  <= bus.dividend;
                    done_q <= 1'b1;
                end else begin
                    dvd_q   <= mag(bus.dividend, bus.signed_op);
                    dsr_q   <= mag(bus.divisor, bus.signed_op);
                    q_neg_q <= bus.signed_op &
                               (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    r_neg_q <= bus.signed_op & bus.dividend[WIDTH-1];
                    rem_q   <= '0;
                    cnt_q   <= '0;
                end
            end else if (state_q == CALC) begin
                rem_q <= rem_nx;
                dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                cnt_q <= cnt_q + 4'd1;
            end else if (state_q == FIX) begin
                quo_q  <= q_neg_q ? WIDTH'(-dvd_q) : dvd_q;
                rmd_q  <= r_neg_q ? WIDTH'(-rem_q) : rem_q;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_div_unit_16.sv
// Directed bench for div_unit_16.
// Hand-computed vectors; immediate assertions at every check.
module tb_div_unit_16;
    import mips16_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    div_unit_16_if bus ();

    div_unit_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s,
                         input logic [15:0] a,
                         input logic [15:0] b);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
    endtask

    // Waits for done, returns cycles counted after the accepting edge.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy && bus.done) chk("busy_and_done", 16'd1, 16'd0);
            step();
            n++;
        end
        if (!bus.done) chk("done_timeout", 16'd0, 16'd1);
    endtask

    task automatic run_op(input string tag,
                          input logic s,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [15:0] eq,
                          input logic [15:0] er,
                          input logic edz,
                          input int elat);
        int n;
        drive(s, a, b);
        step();
        bus.start = 1'b0;
        wait_done(n);
        chk({tag, "_lat"}, 16'(n), 16'(elat));
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, bus.remainder, er);
        chk({tag, "_dz"}, {15'd0, bus.div_zero}, {15'd0, edz});
        chk({tag, "_busy"}, {15'd0, bus.busy}, 16'd0);
        step();
        chk({tag, "_pulse"}, {15'd0, bus.done}, 16'd0);
    endtask

    initial begin
        int n;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        step();
        step();
        chk("rst_q", bus.quotient, 16'h0000);
        chk("rst_r", bus.remainder, 16'h0000);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);
        chk("rst_dz", {15'd0, bus.div_zero}, 16'd0);
        rst_n = 1'b1;
        step();

        run_op("u100_7", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        run_op("s_m7_2", 1'b1, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 17);
        run_op("u_m7_2", 1'b0, 16'hFFF9, 16'd2, 16'h7FFC, 16'h0001, 1'b0, 17);
        run_op("s_ovf", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17);
        run_op("u_ffff_1", 1'b0, 16'hFFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 17);
        run_op("s_7_m2", 1'b1, 16'd7, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17);

        drive(1'b0, 16'd1234, 16'd0);
        step();
        bus.start = 1'b0;
        chk("dz_done", {15'd0, bus.done}, 16'd1);
        chk("dz_busy", {15'd0, bus.busy}, 16'd0);
        chk("dz_q", bus.quotient, 16'hFFFF);
        chk("dz_r", bus.remainder, 16'd1234);
        chk("dz_flag", {15'd0, bus.div_zero}, 16'd1);
        step();
        chk("dz_pulse", {15'd0, bus.done}, 16'd0);
        chk("dz_busy2", {15'd0, bus.busy}, 16'd0);

        run_op("u9_3", 1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

        // Start during busy is ignored; outputs hold mid-operation.
        drive(1'b0, 16'd20, 16'd4);
        step();
        bus.start = 1'b0;
        step();
        step();
        drive(1'b0, 16'd99, 16'd9);
        step();
        bus.start = 1'b0;
        chk("hold_q", bus.quotient, 16'd3);
        chk("hold_busy", {15'd0, bus.busy}, 16'd1);
        wait_done(n);
        chk("ign_lat", 16'(n + 3), 16'd17);
        chk("ign_q", bus.quotient, 16'd5);
        chk("ign_r", bus.remainder, 16'd0);

        // Start in the done cycle is accepted.
        drive(1'b0, 16'd1000, 16'd3);
        step();
        bus.start = 1'b0;
        chk("b2b_busy", {15'd0, bus.busy}, 16'd1);
        wait_done(n);
        chk("b2b_gap", 16'(n + 1), 16'd18);
        chk("b2b_q", bus.quotient, 16'd333);
        chk("b2b_r", bus.remainder, 16'd1);
        step();

        // Reset mid-operation.
        drive(1'b1, 16'd777, 16'd7);
        step();
        bus.start = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_q", bus.quotient, 16'h0000);
        chk("mrst_r", bus.remainder, 16'h0000);
        chk("mrst_busy", {15'd0, bus.busy}, 16'd0);
        chk("mrst_done", {15'd0, bus.done}, 16'd0);
        step();
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            step();
            if (bus.done) n++;
        end
        chk("mrst_nodone", 16'(n), 16'd0);
        chk("mrst_idle", {15'd0, bus.busy}, 16'd0);

        run_op("u50_5", 1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
